// File: rtl/sum_inverse_unit.sv
// sum_inverse_unit: recovers the largest N with 1+2+...+N <= S by repeated
// subtraction of an incrementing counter from a remainder register. Also
// reports the leftover remainder, an exact-match flag and an overflow flag.
module sum_inverse_unit #(
  parameter int unsigned N_W = 8,
  parameter int unsigned S_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N_W-1:0] inBus,
  input  logic           loadLo,
  input  logic           loadHi,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] nOut,
  output logic [S_W-1:0] remOut,
  output logic           exact,
  output logic           ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // k reaching this value means N has hit the top of its range
  localparam logic [N_W:0]   KLimit = {1'b1, {N_W{1'b0}}};
  localparam logic [S_W-1:0] RemLim = {{(S_W-N_W-1){1'b0}}, 1'b1, {N_W{1'b0}}};

  state_e         state_q, state_d;
  logic [S_W-1:0] s_q;
  logic [S_W-1:0] rem_q;
  logic [N_W:0]   k_q;
  logic [S_W-1:0] k_ext;
  logic           run_end;
  logic           load_ok;

  assign k_ext   = {{(S_W-N_W-1){1'b0}}, k_q};
  assign run_end = (k_q > {1'b0, {N_W{1'b1}}}) || (rem_q < k_ext);
  assign load_ok = (state_q == StIdle) || (state_q == StDone);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (run_end) state_d = StDone;
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Sum register: byte loads accepted only while not computing
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else if (load_ok) begin
      if (loadLo) s_q[N_W-1:0]   <= inBus;
      if (loadHi) s_q[S_W-1:N_W] <= inBus;
    end
  end

  // Datapath: remainder/counter iteration and result capture on RUN exit
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      k_q    <= '0;
      nOut   <= '0;
      remOut <= '0;
      exact  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            // uses the pre-load S when a load lands in the same cycle
            rem_q <= s_q;
            k_q   <= {{N_W{1'b0}}, 1'b1};
          end
        end
        StRun: begin
          if (run_end) begin
            nOut   <= k_q[N_W-1:0] - {{(N_W-1){1'b0}}, 1'b1};
            remOut <= rem_q;
            exact  <= (rem_q == '0);
            ovf    <= (k_q == KLimit) && (rem_q >= RemLim);
          end else begin
            // never underflows: only reached when rem_q >= k
            rem_q <= rem_q - k_ext;
            k_q   <= k_q + {{N_W{1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
